// File: rtl/dmem_store_buffer_pkg.sv
// Shared types and constants for the data-memory store buffer.
// Optional error reporting is enabled by defining DMEM_ERR_EN.
package dmem_store_buffer_pkg;

    localparam int SB_DEPTH_DEFAULT  = 4;
    localparam int MEM_WORDS_DEFAULT = 1024;
    localparam int ERR_OVERFLOW_BIT  = 0;
    localparam int ERR_MISALIGN_BIT  = 1;

    // Wide enough for any word index of a 32-bit byte address.
    localparam int INDEX_W = 30;

    typedef struct packed {
        logic [INDEX_W-1:0] index;
        logic [31:0]        data;
    } sb_entry_t;

    function automatic logic is_misaligned(input logic [1:0] byte_offset);
        return byte_offset != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_store_buffer_sb_fifo.sv
// Circular store-buffer FIFO with a youngest-match associative lookup.
// Part of dmem_store_buffer (optional macro DMEM_ERR_EN lives in the top).
module sb_fifo
    import dmem_store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  sb_entry_t          push_entry,
    input  logic               pop,
    output sb_entry_t          head_entry,
    output logic               full,
    output logic               empty,
    input  logic [INDEX_W-1:0] lookup_index,
    output logic               hit,
    output logic [31:0]        hit_data
);

    localparam int PW = $clog2(DEPTH);

    sb_entry_t        entries_r [DEPTH];
    logic [PW-1:0]    head_r;
    logic [PW-1:0]    tail_r;
    logic [PW:0]      count_r;
    logic [PW-1:0]    slot_s;

    // Pointer, occupancy and entry storage update
    always_ff @(posedge clk) begin
        if (reset) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (push) begin
                entries_r[tail_r] <= push_entry;
                tail_r            <= tail_r + 1'b1;
            end
            if (pop) begin
                head_r <= head_r + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign head_entry = entries_r[head_r];
    assign full       = (count_r == (PW+1)'(DEPTH));
    assign empty      = (count_r == '0);

    // Scan oldest to youngest so the last valid match is the youngest one
    always_comb begin
        hit      = 1'b0;
        hit_data = 32'h0000_0000;
        slot_s   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_s = head_r + i[PW-1:0];
            if (((PW+1)'(i) < count_r) && (entries_r[slot_s].index == lookup_index)) begin
                hit      = 1'b1;
                hit_data = entries_r[slot_s].data;
            end else begin
                hit      = hit;
                hit_data = hit_data;
            end
        end
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// Data memory with a store buffer, load forwarding and a tri-stated data bus.
// Define DMEM_ERR_EN to enable sticky overflow/misalignment flags.
module dmem_store_buffer
    import dmem_store_buffer_pkg::*;
#(
    parameter int DEPTH     = SB_DEPTH_DEFAULT,
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] daddrbus,
    inout  wire  [31:0] databus,
    input  logic        store_en,
    input  logic        load_en,
    output logic        sb_full,
    output logic        sb_empty,
    output logic [1:0]  err_flags
);

    localparam int IW = $clog2(MEM_WORDS);

    logic [31:0]   mem_r [MEM_WORDS];
    logic [IW-1:0] word_idx_s;
    logic          load_cycle_s;
    logic          push_s;
    logic          pop_s;
    sb_entry_t     push_entry_s;
    sb_entry_t     head_entry_s;
    logic          hit_s;
    logic [31:0]   hit_data_s;
    logic [31:0]   load_data_s;
    logic          unused_bits_s;

    assign word_idx_s   = daddrbus[IW+1:2];
    assign load_cycle_s = load_en & ~store_en;
    assign push_s       = store_en & ~sb_full;
    // The array port is shared with the load read, so loads block draining.
    assign pop_s        = ~sb_empty & ~load_en;
    assign push_entry_s = '{index: INDEX_W'(word_idx_s), data: databus};

    sb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push         (push_s),
        .push_entry   (push_entry_s),
        .pop          (pop_s),
        .head_entry   (head_entry_s),
        .full         (sb_full),
        .empty        (sb_empty),
        .lookup_index (INDEX_W'(word_idx_s)),
        .hit          (hit_s),
        .hit_data     (hit_data_s)
    );

    // Drain the oldest buffered store into the array; array survives reset
    always_ff @(posedge clk) begin
        if (!reset && pop_s) begin
            mem_r[head_entry_s.index[IW-1:0]] <= head_entry_s.data;
        end
    end

    assign load_data_s = hit_s ? hit_data_s : mem_r[word_idx_s];
    assign databus     = load_cycle_s ? load_data_s : {32{1'bz}};

    assign unused_bits_s = ^{daddrbus[31:IW+2], daddrbus[1:0], head_entry_s.index[INDEX_W-1:IW]};

`ifdef DMEM_ERR_EN
    logic [1:0] err_r;

    // Sticky error capture, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            err_r <= 2'b00;
        end else begin
            if (store_en && sb_full) begin
                err_r[ERR_OVERFLOW_BIT] <= 1'b1;
            end
            if ((store_en || load_en) && is_misaligned(daddrbus[1:0])) begin
                err_r[ERR_MISALIGN_BIT] <= 1'b1;
            end
        end
    end

    assign err_flags = err_r;
`else
    assign err_flags = 2'b00;
`endif

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Scoreboard bench for dmem_store_buffer: stimulus queues expectations, a monitor checks them.
module tb_dmem_store_buffer;

    localparam int K_FULL  = 0;
    localparam int K_EMPTY = 1;
    localparam int K_ERR   = 2;

`ifdef DMEM_ERR_EN
    localparam logic [31:0] EXP_OVF_ERR = 32'd1;
    localparam logic [31:0] EXP_MIS_ERR = 32'd2;
`else
    localparam logic [31:0] EXP_OVF_ERR = 32'd0;
    localparam logic [31:0] EXP_MIS_ERR = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] daddrbus;
    wire  [31:0] databus;
    logic        store_en;
    logic        load_en;
    logic        sb_full;
    logic        sb_empty;
    logic [1:0]  err_flags;
    logic [31:0] cpu_data;
    logic        cpu_drive;
    logic        probe;

    int n_checks = 0;
    int n_pass   = 0;

    string       data_name [$];
    logic [31:0] data_val  [$];
    string       stat_name [$];
    int          stat_kind [$];
    logic [31:0] stat_val  [$];

    assign databus = cpu_drive ? cpu_data : {32{1'bz}};

    dmem_store_buffer dut (
        .clk       (clk),
        .reset     (reset),
        .daddrbus  (daddrbus),
        .databus   (databus),
        .store_en  (store_en),
        .load_en   (load_en),
        .sb_full   (sb_full),
        .sb_empty  (sb_empty),
        .err_flags (err_flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: loads pop the data queue, probed cycles pop the status queue
    always @(negedge clk) begin
        if (load_en && !store_en) begin
            if (data_val.size() == 0) begin
                n_checks++;
                $display("FAIL load_unexpected: got load of %h expected no load", daddrbus);
            end else begin
                check(data_name.pop_front(), databus, data_val.pop_front());
            end
        end
        if (probe) begin
            while (stat_kind.size() > 0) begin
                string nm;
                int k;
                logic [31:0] act;
                nm = stat_name.pop_front();
                k  = stat_kind.pop_front();
                if (k == K_FULL)       act = {31'd0, sb_full};
                else if (k == K_EMPTY) act = {31'd0, sb_empty};
                else                   act = {30'd0, err_flags};
                check(nm, act, stat_val.pop_front());
            end
        end
    end

    task automatic op(input logic st, input logic ld, input logic [31:0] addr, input logic [31:0] d);
        store_en  = st;
        load_en   = ld;
        daddrbus  = addr;
        cpu_data  = d;
        cpu_drive = st;
        @(posedge clk);
        #1;
        probe = 1'b0;
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic expect_load(input string name, input logic [31:0] v);
        data_name.push_back(name);
        data_val.push_back(v);
    endtask

    task automatic expect_stat(input string name, input int kind, input logic [31:0] v);
        stat_name.push_back(name);
        stat_kind.push_back(kind);
        stat_val.push_back(v);
        probe = 1'b1;
    endtask

    initial begin
        reset = 1'b1; probe = 1'b0;
        store_en = 1'b0; load_en = 1'b0; daddrbus = 32'h0; cpu_data = 32'h0; cpu_drive = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        expect_stat("rst_empty", K_EMPTY, 32'd1);
        expect_stat("rst_full",  K_FULL,  32'd0);
        expect_stat("rst_err",   K_ERR,   32'd0);
        idle();

        // Forwarding before the array is written
        op(1'b1, 1'b0, 32'h40, 32'hDEADBEEF);
        expect_load("fwd_40", 32'hDEADBEEF);
        expect_stat("fwd_still_buffered", K_EMPTY, 32'd0);
        op(1'b0, 1'b1, 32'h40, 32'h0);
        idle();
        expect_load("arr_40", 32'hDEADBEEF);
        expect_stat("drained_empty", K_EMPTY, 32'd1);
        op(1'b0, 1'b1, 32'h40, 32'h0);

        // Youngest match wins
        op(1'b1, 1'b1, 32'h80, 32'h11);
        op(1'b1, 1'b1, 32'h80, 32'h22);
        expect_load("young_80", 32'h22);
        op(1'b0, 1'b1, 32'h80, 32'h0);
        idle();
        idle();
        expect_load("arr_80", 32'h22);
        op(1'b0, 1'b1, 32'h80, 32'h0);

        // Fill, overflow drop, in-order drain
        for (int i = 0; i < 4; i++) op(1'b1, 1'b1, 32'h100 + 32'(4*i), 32'hA1 + 32'(i));
        expect_stat("full_after_4", K_FULL, 32'd1);
        op(1'b1, 1'b1, 32'h100, 32'h55);
        expect_stat("full_after_drop", K_FULL, 32'd1);
        expect_stat("ovf_err", K_ERR, EXP_OVF_ERR);
        expect_load("drop_fwd_100", 32'hA1);
        op(1'b0, 1'b1, 32'h100, 32'h0);
        idle(); idle(); idle();
        expect_stat("not_empty_after_3", K_EMPTY, 32'd0);
        idle();
        expect_stat("empty_after_4", K_EMPTY, 32'd1);
        expect_stat("not_full_after_4", K_FULL, 32'd0);
        for (int i = 0; i < 4; i++) begin
            expect_load($sformatf("drain_order_%0d", i), 32'hA1 + 32'(i));
            op(1'b0, 1'b1, 32'h100 + 32'(4*i), 32'h0);
        end

        // Address wrap-around: 0x1000 aliases word 0
        op(1'b1, 1'b0, 32'h1000, 32'hCAFE0001);
        idle();
        expect_load("wrap_0", 32'hCAFE0001);
        expect_stat("wrap_drained", K_EMPTY, 32'd1);
        op(1'b0, 1'b1, 32'h0, 32'h0);

        // Reset mid-operation discards buffered stores but keeps the array
        op(1'b1, 1'b0, 32'h44, 32'h12345678);
        idle();
        op(1'b1, 1'b1, 32'h44, 32'hA5);
        op(1'b1, 1'b1, 32'h48, 32'h1);
        op(1'b1, 1'b1, 32'h4C, 32'h2);
        op(1'b1, 1'b1, 32'h50, 32'h3);
        expect_stat("full_before_reset", K_FULL, 32'd1);
        reset = 1'b1;
        op(1'b1, 1'b0, 32'h44, 32'h77);
        reset = 1'b0;
        expect_stat("post_rst_empty", K_EMPTY, 32'd1);
        expect_stat("post_rst_full",  K_FULL,  32'd0);
        expect_stat("post_rst_err",   K_ERR,   32'd0);
        expect_load("post_rst_44", 32'h12345678);
        op(1'b0, 1'b1, 32'h44, 32'h0);

        // Misaligned load uses the word index
        expect_load("mis_42", 32'hDEADBEEF);
        op(1'b0, 1'b1, 32'h42, 32'h0);
        expect_stat("mis_err", K_ERR, EXP_MIS_ERR);
        idle();
        idle();

        if (data_val.size() != 0 || stat_kind.size() != 0) begin
            n_checks++;
            $display("FAIL leftover_expectations: got %0d pending expected 0",
                     data_val.size() + stat_kind.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
